// File: rtl/tc_period_checker.sv
`default_nettype none
//============================================================================
// Module      : tc_period_checker
// Description : Measures the number of enabled clock cycles between
//               successive terminal-count pulses on tc_in and compares each
//               interval against EXP_PERIOD. Reports lock, a per-period pass
//               pulse, a sticky error flag and a saturating error count.
// Revision    : 1.0 - initial release
//----------------------------------------------------------------------------
// Ports
//   clk          in   system clock
//   reset_n      in   asynchronous active-low reset
//   en           in   chain enable; when low the measurement freezes
//   clr          in   synchronous statistics clear (highest priority)
//   tc_in        in   terminal-count pulse under test
//   locked       out  LOCK_N consecutive good periods since last error/clear
//   pass_pulse   out  one-cycle pulse per good period
//   err_sticky   out  set on any error, cleared by clr/reset
//   err_count    out  saturating (255) error count
//   last_period  out  most recently measured interval
//   armed        out  waiting for a reference pulse
//============================================================================
module tc_period_checker #(
  parameter int EXP_PERIOD = 65536,
  parameter int SLACK      = 4,
  parameter int CNT_W      = 32,
  parameter int LOCK_N     = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             clr,
  input  logic             tc_in,
  output logic             locked,
  output logic             pass_pulse,
  output logic             err_sticky,
  output logic [7:0]       err_count,
  output logic [CNT_W-1:0] last_period,
  output logic             armed
);

  localparam int GR_W = (LOCK_N < 1) ? 1 : $clog2(LOCK_N + 1);

  localparam logic [CNT_W-1:0] c_EXP      = CNT_W'(EXP_PERIOD);
  // Counter value on the last cycle a pulse could still arrive "late";
  // one more empty cycle means the pulse is declared missing.
  localparam logic [CNT_W-1:0] c_TMO_LAST = CNT_W'(EXP_PERIOD + SLACK - 1);
  localparam logic [CNT_W-1:0] c_TMO_VAL  = CNT_W'(EXP_PERIOD + SLACK);
  localparam logic [GR_W-1:0]  c_LOCK     = GR_W'(LOCK_N);
  localparam logic [CNT_W-1:0] c_ONE      = CNT_W'(1);

  typedef enum logic [0:0] {
    ST_ARM  = 1'b0,
    ST_MEAS = 1'b1
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [GR_W-1:0]  r_good_run;
  logic             r_locked;
  logic             r_pass;
  logic             r_sticky;
  logic [7:0]       r_err_count;
  logic [CNT_W-1:0] r_last;
  logic             r_armed;

  logic             w_meas;
  logic             w_hit;
  logic             w_good;
  logic             w_timeout;
  logic             w_error;
  logic [GR_W-1:0]  w_good_run_inc;
  logic [7:0]       w_err_count_inc;

  // Event decode. A pulse on the timeout cycle wins over the timeout.
  assign w_meas    = en && (r_state == ST_MEAS);
  assign w_hit     = w_meas && tc_in;
  assign w_good    = w_hit && (r_cnt == c_EXP);
  assign w_timeout = w_meas && !tc_in && (r_cnt == c_TMO_LAST);
  assign w_error   = (w_hit && !w_good) || w_timeout;

  assign w_good_run_inc  = (r_good_run == c_LOCK) ? r_good_run : r_good_run + GR_W'(1);
  assign w_err_count_inc = (r_err_count == 8'hFF) ? r_err_count : r_err_count + 8'd1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_ARM;
      r_cnt       <= '0;
      r_good_run  <= '0;
      r_locked    <= 1'b0;
      r_pass      <= 1'b0;
      r_sticky    <= 1'b0;
      r_err_count <= '0;
      r_last      <= '0;
      r_armed     <= 1'b1;
    end else if (clr) begin
      // Clear discards any coincident tc_in and keeps last_period.
      r_state     <= ST_ARM;
      r_cnt       <= '0;
      r_good_run  <= '0;
      r_locked    <= 1'b0;
      r_pass      <= 1'b0;
      r_sticky    <= 1'b0;
      r_err_count <= '0;
      r_armed     <= 1'b1;
    end else begin
      r_pass <= 1'b0;

      if (en) begin
        case (r_state)
          ST_ARM: begin
            if (tc_in) begin
              r_cnt   <= c_ONE;
              r_state <= ST_MEAS;
              r_armed <= 1'b0;
            end
          end
          ST_MEAS: begin
            if (tc_in) begin
              // Every pulse is both the end of one interval and the
              // reference for the next.
              r_last <= r_cnt;
              r_cnt  <= c_ONE;
            end else if (w_timeout) begin
              r_last  <= c_TMO_VAL;
              r_cnt   <= '0;
              r_state <= ST_ARM;
              r_armed <= 1'b1;
            end else begin
              r_cnt <= r_cnt + c_ONE;
            end
          end
          default: begin
            r_state <= ST_ARM;
            r_armed <= 1'b1;
          end
        endcase
      end

      if (w_good) begin
        r_pass     <= 1'b1;
        r_good_run <= w_good_run_inc;
        r_locked   <= (w_good_run_inc == c_LOCK);
      end

      if (w_error) begin
        r_sticky    <= 1'b1;
        r_err_count <= w_err_count_inc;
        r_good_run  <= '0;
        r_locked    <= 1'b0;
      end
    end
  end

  assign locked      = r_locked;
  assign pass_pulse  = r_pass;
  assign err_sticky  = r_sticky;
  assign err_count   = r_err_count;
  assign last_period = r_last;
  assign armed       = r_armed;

endmodule
`default_nettype wire

// File: tb/tb_tc_period_checker.sv
`default_nettype none
//============================================================================
// Module      : tb_tc_period_checker
// Description : Self-checking bench for tc_period_checker. Table-driven
//               pulse-train vectors, hand-written corner sequences and a
//               randomized phase, all checked against a timestamp-based
//               reference model.
// Revision    : 1.0 - initial release
//============================================================================
module tb_tc_period_checker;

  localparam int P_EXP   = 16;
  localparam int P_SLACK = 4;
  localparam int P_CNT_W = 32;
  localparam int P_LOCK  = 2;

  logic        clk;
  logic        reset_n;
  logic        en;
  logic        clr;
  logic        tc_in;
  logic        locked;
  logic        pass_pulse;
  logic        err_sticky;
  logic [7:0]  err_count;
  logic [31:0] last_period;
  logic        armed;

  int n_cmp = 0;
  int n_bad = 0;

  tc_period_checker #(
    .EXP_PERIOD (P_EXP),
    .SLACK      (P_SLACK),
    .CNT_W      (P_CNT_W),
    .LOCK_N     (P_LOCK)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .en          (en),
    .clr         (clr),
    .tc_in       (tc_in),
    .locked      (locked),
    .pass_pulse  (pass_pulse),
    .err_sticky  (err_sticky),
    .err_count   (err_count),
    .last_period (last_period),
    .armed       (armed)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: timestamps in enabled cycles. The interval is simply
  // "enabled cycles now" minus "enabled cycles at the reference pulse".
  int          m_ecyc;
  int          m_ref;
  bit          m_armed;
  int          m_good;
  bit          m_pass;
  bit          m_sticky;
  int          m_errs;
  logic [31:0] m_last;

  function automatic void model_reset(input bit keep_last);
    m_ecyc   = 0;
    m_ref    = 0;
    m_armed  = 1'b1;
    m_good   = 0;
    m_pass   = 1'b0;
    m_sticky = 1'b0;
    m_errs   = 0;
    if (!keep_last) m_last = '0;
  endfunction

  function automatic void model_error();
    m_sticky = 1'b1;
    m_errs   = (m_errs < 255) ? m_errs + 1 : 255;
    m_good   = 0;
  endfunction

  function automatic void model_step(input bit e, input bit t, input bit c);
    int d;
    m_pass = 1'b0;
    if (c) begin
      model_reset(1'b1);
    end else if (e) begin
      m_ecyc++;
      d = m_ecyc - m_ref;
      if (m_armed) begin
        if (t) begin
          m_ref   = m_ecyc;
          m_armed = 1'b0;
        end
      end else if (t) begin
        m_last = 32'(d);
        m_ref  = m_ecyc;
        if (d == P_EXP) begin
          m_pass = 1'b1;
          m_good++;
        end else begin
          model_error();
        end
      end else if (d == P_EXP + P_SLACK - 1) begin
        // Pulse would now be later than EXP+SLACK: declared missing.
        model_error();
        m_last  = 32'(P_EXP + P_SLACK);
        m_armed = 1'b1;
      end
    end
  endfunction

  task automatic check_exp(input string nm, input logic e_lock, input logic e_pass,
                           input logic e_stk, input logic [7:0] e_cnt,
                           input logic [31:0] e_last, input logic e_arm);
    logic [43:0] act;
    logic [43:0] exp;
    act = {locked, pass_pulse, err_sticky, err_count, last_period, armed};
    exp = {e_lock, e_pass, e_stk, e_cnt, e_last, e_arm};
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got lock=%b pass=%b stk=%b cnt=%0d last=%0d arm=%b, want lock=%b pass=%b stk=%b cnt=%0d last=%0d arm=%b",
               nm, $time, locked, pass_pulse, err_sticky, err_count, last_period, armed,
               e_lock, e_pass, e_stk, e_cnt, e_last, e_arm);
    end
  endtask

  task automatic check_model(input string nm);
    check_exp(nm, m_good >= P_LOCK, m_pass, m_sticky, 8'(m_errs), m_last, m_armed);
  endtask

  // One clock: drive, advance the model, sample 1 time unit after the edge.
  task automatic step(input bit e, input bit t, input bit c, input string nm);
    en    = e;
    tc_in = t;
    clr   = c;
    @(posedge clk);
    model_step(e, t, c);
    #1;
    check_model(nm);
  endtask

  typedef struct {
    string       name;
    int          gap;     // idle enabled cycles before the event cycle
    logic        tc;      // tc_in on the event cycle
    logic        e_lock;
    logic        e_pass;
    logic        e_stk;
    logic [7:0]  e_cnt;
    logic [31:0] e_last;
    logic        e_arm;
  } vec_t;

  vec_t tbl[10];

  initial begin
    bit e, t, c;
    int d;

    tbl[0] = '{"ref_pulse",    3, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 32'd0,  1'b0};
    tbl[1] = '{"good_p2",     15, 1'b1, 1'b0, 1'b1, 1'b0, 8'd0, 32'd16, 1'b0};
    tbl[2] = '{"good_p3_lock",15, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0, 32'd16, 1'b0};
    tbl[3] = '{"good_p4",     15, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0, 32'd16, 1'b0};
    tbl[4] = '{"early_15",    14, 1'b1, 1'b0, 1'b0, 1'b1, 8'd1, 32'd15, 1'b0};
    tbl[5] = '{"relock_1",    15, 1'b1, 1'b0, 1'b1, 1'b1, 8'd1, 32'd16, 1'b0};
    tbl[6] = '{"relock_2",    15, 1'b1, 1'b1, 1'b1, 1'b1, 8'd1, 32'd16, 1'b0};
    tbl[7] = '{"timeout",     18, 1'b0, 1'b0, 1'b0, 1'b1, 8'd2, 32'd20, 1'b1};
    tbl[8] = '{"ref_after_to", 5, 1'b1, 1'b0, 1'b0, 1'b1, 8'd2, 32'd20, 1'b0};
    tbl[9] = '{"back_to_back", 0, 1'b1, 1'b0, 1'b0, 1'b1, 8'd3, 32'd1,  1'b0};

    reset_n = 1'b0;
    en      = 1'b0;
    clr     = 1'b0;
    tc_in   = 1'b0;
    model_reset(1'b0);
    #12;
    check_exp("reset_state", 1'b0, 1'b0, 1'b0, 8'd0, 32'd0, 1'b1);
    #1 reset_n = 1'b1;

    // Table-driven pulse train.
    for (int i = 0; i < 10; i++) begin
      for (int g = 0; g < tbl[i].gap; g++) step(1'b1, 1'b0, 1'b0, "gap");
      step(1'b1, tbl[i].tc, 1'b0, tbl[i].name);
      check_exp(tbl[i].name, tbl[i].e_lock, tbl[i].e_pass, tbl[i].e_stk,
                tbl[i].e_cnt, tbl[i].e_last, tbl[i].e_arm);
    end

    // Enable stall: 26 raw cycles, 16 enabled, with a pulse while stalled.
    for (int g = 0; g < 5; g++) step(1'b1, 1'b0, 1'b0, "en_pre");
    for (int g = 0; g < 10; g++) step(1'b0, (g == 4), 1'b0, "en_low");
    for (int g = 0; g < 10; g++) step(1'b1, 1'b0, 1'b0, "en_post");
    step(1'b1, 1'b1, 1'b0, "en_stall_pass");
    check_exp("en_stall_pass", 1'b0, 1'b1, 1'b1, 8'd3, 32'd16, 1'b0);

    // Drive the error count into saturation with back-to-back pulses.
    for (int g = 0; g < 300; g++) step(1'b1, 1'b1, 1'b0, "sat_burst");
    check_exp("err_saturated", 1'b0, 1'b0, 1'b1, 8'd255, 32'd1, 1'b0);

    // Clear coincident with a pulse: the pulse must not become a reference.
    step(1'b1, 1'b1, 1'b1, "clr_with_tc");
    check_exp("clr_with_tc", 1'b0, 1'b0, 1'b0, 8'd0, 32'd1, 1'b1);
    step(1'b1, 1'b1, 1'b0, "ref_after_clr");
    check_exp("ref_after_clr", 1'b0, 1'b0, 1'b0, 8'd0, 32'd1, 1'b0);
    for (int g = 0; g < 15; g++) step(1'b1, 1'b0, 1'b0, "gap");
    step(1'b1, 1'b1, 1'b0, "pass_after_clr");
    check_exp("pass_after_clr", 1'b0, 1'b1, 1'b0, 8'd0, 32'd16, 1'b0);
    for (int g = 0; g < 15; g++) step(1'b1, 1'b0, 1'b0, "gap");
    step(1'b1, 1'b1, 1'b0, "lock_after_clr");
    check_exp("lock_after_clr", 1'b1, 1'b1, 1'b0, 8'd0, 32'd16, 1'b0);
    step(1'b1, 1'b0, 1'b0, "gap");

    // Asynchronous reset between edges while locked.
    @(posedge clk);
    model_step(1'b1, 1'b0, 1'b0);
    #3 reset_n = 1'b0;
    #1;
    check_exp("async_reset", 1'b0, 1'b0, 1'b0, 8'd0, 32'd0, 1'b1);
    model_reset(1'b0);
    @(posedge clk);
    #3 reset_n = 1'b1;

    // Randomized phase against the model.
    for (int i = 0; i < 3000; i++) begin
      e = ($urandom_range(0, 9) != 0);
      d = m_ecyc + 1 - m_ref;
      if (m_armed)          t = ($urandom_range(0, 7) == 0);
      else if (d == P_EXP)  t = ($urandom_range(0, 9) != 0);
      else                  t = ($urandom_range(0, 49) == 0);
      c = ($urandom_range(0, 299) == 0);
      step(e, t, c, "random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
